// File: rtl/bcd_axil_req_arbiter.sv
// Two-requester round-robin arbiter onto a single AXI4-Lite master port.
// One transaction is in flight at a time, and one response pulse goes back to its owner.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | arbitrate; REQ_READY to the winner, capture its command
// WR     | AWVALID/WVALID up until each handshakes on its own
// WR_B   | BREADY up, waiting for the write response
// RD_A   | ARVALID up until ARREADY
// RD_R   | RREADY up, waiting for read data
// RESP   | one-cycle RSP_VALID pulse to the owner
module bcd_axil_req_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [1:0]                REQ_VALID,
  output logic [1:0]                REQ_READY,
  input  logic [1:0]                REQ_WE,
  input  logic [2*C_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*C_DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]                RSP_VALID,
  output logic [C_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RESP
  } state_t;

  localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                    state, state_nxt;
  logic                      last_grant;
  logic                      owner;
  logic [C_ADDR_WIDTH-1:0]   cap_addr;
  logic [C_DATA_WIDTH-1:0]   cap_wdata;
  logic                      aw_done, w_done;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]                rsp_resp;
  logic                      win;
  logic                      accept;
  logic                      aw_hs, w_hs;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    case (REQ_VALID)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
    accept = (state == S_IDLE) && (REQ_VALID != 2'b00);
    REQ_READY = 2'b00;
    if (accept) REQ_READY[win] = 1'b1;
  end

  assign M_AXI_AWVALID = (state == S_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == S_WR) && !w_done;
  assign M_AXI_BREADY  = (state == S_WR_B);
  assign M_AXI_ARVALID = (state == S_RD_A);
  assign M_AXI_RREADY  = (state == S_RD_R);
  assign M_AXI_AWADDR  = cap_addr & ADDR_MASK;
  assign M_AXI_ARADDR  = cap_addr & ADDR_MASK;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = cap_wdata;
  assign M_AXI_WSTRB   = '1;
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
  assign RSP_VALID     = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_RDATA     = rsp_rdata;
  assign RSP_RESP      = rsp_resp;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = REQ_WE[win] ? S_WR : S_RD_A;
      S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_B;
      S_WR_B: if (M_AXI_BVALID) state_nxt = S_RESP;
      S_RD_A: if (M_AXI_ARREADY) state_nxt = S_RD_R;
      S_RD_R: if (M_AXI_RVALID) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= win;
        last_grant <= win;
        cap_addr   <= win ? REQ_ADDR[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : REQ_ADDR[C_ADDR_WIDTH-1:0];
        cap_wdata  <= win ? REQ_WDATA[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : REQ_WDATA[C_DATA_WIDTH-1:0];
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      // A write response carries no data, so stale read data is cleared.
      if (state == S_WR_B && M_AXI_BVALID) begin
        rsp_resp  <= M_AXI_BRESP;
        rsp_rdata <= '0;
      end
      if (state == S_RD_R && M_AXI_RVALID) begin
        rsp_resp  <= M_AXI_RRESP;
        rsp_rdata <= M_AXI_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_bcd_axil_req_arbiter.sv
// Bench for bcd_axil_req_arbiter: a behavioural AXI4-Lite slave with programmable READY
// delays, a table of single transactions, and hand-written arbitration and reset sequences.
module tb_bcd_axil_req_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [1:0]  REQ_VALID, REQ_READY, REQ_WE;
  logic [7:0]  REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [1:0]  RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  logic        rv [2];
  logic        rwe [2];
  logic [3:0]  ra [2];
  logic [31:0] rd [2];

  assign REQ_VALID = {rv[1], rv[0]};
  assign REQ_WE    = {rwe[1], rwe[0]};
  assign REQ_ADDR  = {ra[1], ra[0]};
  assign REQ_WDATA = {rd[1], rd[0]};

  bcd_axil_req_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0;
  bit          err_en = 0;
  logic [31:0] mem [4];
  bit          got_aw, got_w, got_ar;
  int          aw_cnt, w_cnt;
  logic [3:0]  s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  initial begin : slave
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    got_aw = 0; got_w = 0; got_ar = 0; aw_cnt = 0; w_cnt = 0;
    s_awaddr = 0; s_araddr = 0; s_awprot = 0; s_arprot = 0; s_wdata = 0; s_wstrb = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        got_aw = 0; got_w = 0; got_ar = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (M_AXI_BVALID) begin M_AXI_BVALID = 0; got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; end
        if (M_AXI_RVALID) begin M_AXI_RVALID = 0; got_ar = 0; end
        if (M_AXI_AWREADY) begin M_AXI_AWREADY = 0; got_aw = 1; end
        if (M_AXI_WREADY)  begin M_AXI_WREADY = 0;  got_w = 1;  end
        if (M_AXI_ARREADY) begin M_AXI_ARREADY = 0; got_ar = 1; end
        if (got_aw) chk("awvalid_after_hs", M_AXI_AWVALID, 0);
        if (got_w)  chk("wvalid_after_hs", M_AXI_WVALID, 0);
        if (got_ar) chk("arvalid_after_hs", M_AXI_ARVALID, 0);
        if (M_AXI_AWVALID && !got_aw) begin
          if (aw_cnt >= aw_delay) begin
            M_AXI_AWREADY = 1; s_awaddr = M_AXI_AWADDR; s_awprot = M_AXI_AWPROT;
          end else aw_cnt++;
        end
        if (M_AXI_WVALID && !got_w) begin
          if (w_cnt >= w_delay) begin
            M_AXI_WREADY = 1; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB;
          end else w_cnt++;
        end
        if (got_aw && got_w && M_AXI_BREADY) begin
          if (err_en && s_awaddr == 4'hC) M_AXI_BRESP = 2'b10;
          else begin M_AXI_BRESP = 2'b00; mem[s_awaddr[3:2]] = s_wdata; end
          M_AXI_BVALID = 1;
        end
        if (M_AXI_ARVALID && !got_ar) begin
          M_AXI_ARREADY = 1; s_araddr = M_AXI_ARADDR; s_arprot = M_AXI_ARPROT;
        end
        if (got_ar && M_AXI_RREADY) begin
          M_AXI_RDATA  = mem[s_araddr[3:2]];
          M_AXI_RRESP  = (err_en && s_araddr == 4'hC) ? 2'b11 : 2'b00;
          M_AXI_RVALID = 1;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int rsp_cnt = 0, txn_cnt = 0, ready_both = 0, rsp_both = 0;
  int accept_log [$];

  always @(negedge ACLK) begin
    if (RSP_VALID[0]) rsp_cnt++;
    if (RSP_VALID[1]) rsp_cnt++;
    if (REQ_READY == 2'b11) ready_both++;
    if (RSP_VALID == 2'b11) rsp_both++;
  end

  task automatic do_req(input int id, input bit we, input logic [3:0] addr,
                        input logic [31:0] wdata, output bit ok,
                        output logic [31:0] rdata, output logic [1:0] resp, output int lat);
    int n;
    bit acc;
    ok = 0; rdata = 0; resp = 0; lat = 0; acc = 0; n = 0;
    @(negedge ACLK);
    rv[id] = 1; rwe[id] = we; ra[id] = addr; rd[id] = wdata;
    while (!acc && n < 200) begin
      #1;
      if (REQ_READY[id]) begin @(posedge ACLK); acc = 1; end
      else begin @(negedge ACLK); n++; end
    end
    chk($sformatf("r%0d_accepted", id), acc, 1);
    if (acc) begin
      accept_log.push_back(id);
      #1 rv[id] = 0;
      n = 0;
      while (!ok && n < 200) begin
        @(negedge ACLK);
        n++;
        if (RSP_VALID[id]) begin ok = 1; rdata = RSP_RDATA; resp = RSP_RESP; lat = n; end
      end
      if (ok) begin
        txn_cnt++;
        @(negedge ACLK);
        chk($sformatf("r%0d_rsp_one_cycle", id), RSP_VALID[id], 0);
      end
    end else rv[id] = 0;
  endtask

  typedef struct {
    int          id;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          awd;
    int          wd;
    bit          err;
    logic [3:0]  exp_ax;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok0, ok1;
    logic [31:0] rdat0, rdat1;
    logic [1:0] resp0, resp1;
    int lat0, lat1, snap;

    vecs[0] = '{0, 1, 4'h4, 32'h0000_0012, 0, 0, 0, 4'h4, 32'h0,         2'b00, 3};
    vecs[1] = '{1, 0, 4'h4, 32'h0,         0, 0, 0, 4'h4, 32'h0000_0012, 2'b00, 3};
    vecs[2] = '{0, 1, 4'h0, 32'hA5A5_0001, 0, 3, 0, 4'h0, 32'h0,         2'b00, 6};
    vecs[3] = '{1, 1, 4'h8, 32'h0000_00C3, 3, 0, 0, 4'h8, 32'h0,         2'b00, 6};
    vecs[4] = '{1, 0, 4'h2, 32'h0,         0, 0, 0, 4'h0, 32'hA5A5_0001, 2'b00, 3};
    vecs[5] = '{0, 1, 4'hC, 32'h0000_DEAD, 0, 0, 1, 4'hC, 32'h0,         2'b10, 3};
    vecs[6] = '{1, 0, 4'h8, 32'h0,         0, 0, 1, 4'h8, 32'h0000_00C3, 2'b00, 3};
    vecs[7] = '{0, 0, 4'hC, 32'h0,         0, 0, 1, 4'hC, 32'h0000_0022, 2'b11, 3};
    vecs[8] = '{0, 1, 4'h7, 32'h0000_005A, 0, 0, 0, 4'h4, 32'h0,         2'b00, 3};
    vecs[9] = '{1, 0, 4'h4, 32'h0,         1, 1, 0, 4'h4, 32'h0000_005A, 2'b00, 3};

    for (int i = 0; i < 2; i++) begin rv[i] = 0; rwe[i] = 0; ra[i] = 0; rd[i] = 0; end

    // reset state
    repeat (3) @(negedge ACLK);
    chk("rst_in_awvalid", M_AXI_AWVALID, 0);
    chk("rst_in_wvalid", M_AXI_WVALID, 0);
    chk("rst_in_arvalid", M_AXI_ARVALID, 0);
    chk("rst_in_bready", M_AXI_BREADY, 0);
    chk("rst_in_rready", M_AXI_RREADY, 0);
    chk("rst_in_rsp_valid", RSP_VALID, 0);
    chk("rst_in_rsp_rdata", RSP_RDATA, 0);
    chk("rst_in_rsp_resp", RSP_RESP, 0);
    ARESETN = 1;
    @(negedge ACLK);
    chk("post_rst_req_ready", REQ_READY, 0);
    chk("post_rst_wstrb", M_AXI_WSTRB, 4'hF);

    // both valid straight from reset: req0 first
    accept_log.delete();
    fork
      do_req(0, 1, 4'h8, 32'h11, ok0, rdat0, resp0, lat0);
      do_req(1, 1, 4'hC, 32'h22, ok1, rdat1, resp1, lat1);
    join
    chk("pairA_count", accept_log.size(), 2);
    if (accept_log.size() == 2) begin
      chk("pairA_first", accept_log[0], 0);
      chk("pairA_second", accept_log[1], 1);
    end
    chk("pairA_ok0", ok0, 1);
    chk("pairA_ok1", ok1, 1);
    chk("pairA_resp1", resp1, 0);

    foreach (vecs[i]) begin
      aw_delay = vecs[i].awd; w_delay = vecs[i].wd; err_en = vecs[i].err;
      do_req(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, ok0, rdat0, resp0, lat0);
      chk($sformatf("v%0d_rsp_seen", i), ok0, 1);
      if (ok0) begin
        chk($sformatf("v%0d_rdata", i), rdat0, vecs[i].exp_rdata);
        chk($sformatf("v%0d_resp", i), resp0, vecs[i].exp_resp);
        chk($sformatf("v%0d_latency", i), lat0, vecs[i].exp_lat);
        if (vecs[i].we) begin
          chk($sformatf("v%0d_awaddr", i), s_awaddr, vecs[i].exp_ax);
          chk($sformatf("v%0d_wdata", i), s_wdata, vecs[i].wdata);
          chk($sformatf("v%0d_wstrb", i), s_wstrb, 4'hF);
          chk($sformatf("v%0d_awprot", i), s_awprot, 0);
        end else begin
          chk($sformatf("v%0d_araddr", i), s_araddr, vecs[i].exp_ax);
          chk($sformatf("v%0d_arprot", i), s_arprot, 0);
        end
      end
    end
    aw_delay = 0; w_delay = 0; err_en = 0;

    // req0 alone makes it last_grant, so the next tie goes to req1
    do_req(0, 0, 4'h0, 32'h0, ok0, rdat0, resp0, lat0);
    chk("single_r0_rdata", rdat0, 32'hA5A5_0001);
    accept_log.delete();
    fork
      do_req(0, 1, 4'h0, 32'h33, ok0, rdat0, resp0, lat0);
      do_req(1, 1, 4'h4, 32'h44, ok1, rdat1, resp1, lat1);
    join
    chk("pairB_count", accept_log.size(), 2);
    if (accept_log.size() == 2) begin
      chk("pairB_first", accept_log[0], 1);
      chk("pairB_second", accept_log[1], 0);
    end
    chk("pairB_mem0", mem[0], 32'h33);
    chk("pairB_mem1", mem[1], 32'h44);

    // reset while AWVALID is high
    aw_delay = 10; w_delay = 10;
    @(negedge ACLK);
    rv[0] = 1; rwe[0] = 1; ra[0] = 4'h4; rd[0] = 32'h77;
    #1 chk("midrst_ready", REQ_READY, 2'b01);
    @(posedge ACLK);
    #1 rv[0] = 0;
    @(negedge ACLK);
    chk("midrst_awvalid_pre", M_AXI_AWVALID, 1);
    snap = rsp_cnt;
    #2 ARESETN = 0;
    #1;
    chk("midrst_awvalid", M_AXI_AWVALID, 0);
    chk("midrst_wvalid", M_AXI_WVALID, 0);
    chk("midrst_rsp_valid", RSP_VALID, 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    aw_delay = 0; w_delay = 0;
    repeat (8) @(negedge ACLK);
    chk("midrst_no_response", rsp_cnt, snap);
    chk("midrst_mem_untouched", mem[1], 32'h44);
    accept_log.delete();
    fork
      do_req(1, 0, 4'h0, 32'h0, ok1, rdat1, resp1, lat1);
      do_req(0, 0, 4'h4, 32'h0, ok0, rdat0, resp0, lat0);
    join
    chk("pairC_count", accept_log.size(), 2);
    if (accept_log.size() == 2) chk("pairC_first", accept_log[0], 0);
    chk("pairC_rdata0", rdat0, 32'h44);
    chk("pairC_rdata1", rdat1, 32'h33);

    repeat (3) @(negedge ACLK);
    chk("rsp_pulses_total", rsp_cnt, txn_cnt);
    chk("ready_never_both", ready_both, 0);
    chk("rsp_never_both", rsp_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
